turn_signal_ctrl: RTL
=====================

// Module: turn_signal_ctrl
// PURPOSE
//  Front-end controller for the tail-light sequencer. Arbitrates the driver's left, right and hazard
//  requests, and generates the step-rate tick. Holds each request until its light sequence ends.
//  Outputs L/R levels and a one-cycle Step strobe. The sequencer advances only when Step is high.
// PARAMETERS
//  TICK_DIV  4  CLK cycles per Step; must be >= 2; prescaler width = $clog2(TICK_DIV)
// PORTS
//  CLK       in   1  system clock; all state updates on rising edge
//  Reset     in   1  synchronous, active-high reset
//  LeftReq   in   1  left turn lever (level)
//  RightReq  in   1  right turn lever (level)
//  Hazard    in   1  hazard switch (level)
//  L         out  1  left-sequence request to tail-light sequencer
//  R         out  1  right-sequence request to tail-light sequencer
//  Step      out  1  one-cycle advance strobe for the sequencer
//  Phase     out  2  position in current 4-step sequence (0=all off, 1..3 lamps lit)
//  Busy      out  1  high whenever the state is not IDLE
// BEHAVIOUR
//  Reset: the following take effect on the first CLK edge with Reset=1.
//   - div_cnt=0, state=IDLE, Phase=0, L=R=Busy=0, Step=0.
//   - Reset overrides all other inputs.
//  Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps. It runs free in every state.
//   - Step = (div_cnt==TICK_DIV-1), a registered-state decode with no input path.
//   - After reset is released, Step is first high TICK_DIV-1 cycles later, then every TICK_DIV cycles.
//  Request decode (combinational): haz_req = Hazard | (LeftReq & RightReq).
//   - l_req = LeftReq & ~haz_req.
//   - r_req = RightReq & ~haz_req.
//  FSM states: IDLE, LEFT, RIGHT, HAZ. State and Phase change only on edges where Step=1.
//  On Step, by state:
//   - IDLE: priority haz_req -> HAZ, then l_req -> LEFT, then r_req -> RIGHT.
//     In all cases Phase stays 0.
//   - LEFT or RIGHT with haz_req: -> HAZ immediately (preemption), Phase=0.
//   - LEFT/RIGHT/HAZ with Phase<3 and no preemption: Phase+1, state held.
//     A request drop or direction change mid-sequence is ignored until the wrap.
//   - LEFT/RIGHT/HAZ with Phase==3 (wrap): Phase=0, then the next state is re-decoded.
//     Priority: haz_req -> HAZ, then l_req -> LEFT, then r_req -> RIGHT, otherwise IDLE.
//   - HAZ is never preempted. It always completes its sequence.
//  Outputs (registered-state decodes, no combinational input path):
//   - L = (state==LEFT | state==HAZ).
//   - R = (state==RIGHT | state==HAZ).
//   - Busy = (state!=IDLE).
//  Simultaneous events:
//   - Requests changing on a Step cycle are sampled on that edge.
//   - Reset asserted together with Step: Reset wins.
//  Reset mid-sequence: lamps go dark on the next edge. No completion of the sequence.
//  Phase width is fixed at 2 and wraps 3->0. There are no other overflow cases.
// TESTING (TICK_DIV=4; Reset released before cycle 0, so Step is high at cycles 3, 7, 11, 15, 19...)
//  1 LeftReq=1 from cycle 0 -> after the edge at cycle 3: L=1, R=0, Busy=1, Phase=0.
//    Phase then reads 1, 2, 3, 0 after the cycle 7, 11, 15, 19 edges. L stays 1.
//  2 LeftReq dropped at cycle 8, when Phase=1 -> L stays 1 through Phase 2 and 3.
//    After the cycle 19 edge: IDLE, L=0, Busy=0, Phase=0.
//  3 LeftReq->RightReq swap at cycle 9 -> L held until the wrap at cycle 19.
//    Then L=0, R=1, Phase=0. There is no IDLE gap.
//  4 In LEFT at Phase=2, Hazard=1 before the next Step -> on that Step: L=R=1, Phase=0.
//    Hazard then drops mid-sequence -> HAZ runs to Phase 3, then IDLE.
//  5 LeftReq=RightReq=1 from IDLE -> HAZ at the first Step with L=R=1.
//    Releasing RightReq during HAZ -> LEFT after the wrap.
//  6 Reset=1 for one cycle in HAZ at Phase=2 -> next edge: L=R=Busy=0, Phase=0.
//    Step then recurs 3 cycles after release. Also check Step is exactly one cycle wide in every case.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl
// Front end of the tail-light sequencer. It arbitrates the left, right and
// hazard requests and generates the step-rate strobe. A granted request is
// held until its 4-step light sequence wraps. Only hazard may cut a
// left/right sequence short.
module turn_signal_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       LeftReq,
    input  logic       RightReq,
    input  logic       Hazard,
    output logic       L,
    output logic       R,
    output logic       Step,
    output logic [1:0] Phase,
    output logic       Busy
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_t;

    logic [CW-1:0] div_cnt;
    state_t        state;
    state_t        state_nxt;
    state_t        decoded;
    logic [1:0]    phase;
    logic [1:0]    phase_nxt;
    logic          haz_req;
    logic          l_req;
    logic          r_req;
    logic          step_int;

    // Request arbitration: both levers together behave as a hazard request.
    always_comb begin
        haz_req = Hazard | (LeftReq & RightReq);
        l_req   = LeftReq & ~haz_req;
        r_req   = RightReq & ~haz_req;
        decoded = IDLE;
        if (haz_req)
            decoded = HAZ;
        else if (l_req)
            decoded = LEFT;
        else if (r_req)
            decoded = RIGHT;
    end

    // Free-running prescaler; the step strobe is decoded from its last count.
    always_ff @(posedge CLK) begin
        if (Reset)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + CW'(1);
    end

    assign step_int = (div_cnt == DIV_LAST);

    // State and phase registers; they move only on step edges.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            phase <= 2'd0;
        end else if (step_int) begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Next state: hazard preempts left/right at once. Otherwise a running
    // sequence ignores the levers until phase wraps from 3 back to 0.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            IDLE: begin
                state_nxt = decoded;
                phase_nxt = 2'd0;
            end
            LEFT, RIGHT: begin
                if (haz_req) begin
                    state_nxt = HAZ;
                    phase_nxt = 2'd0;
                end else if (phase == 2'd3) begin
                    state_nxt = decoded;
                    phase_nxt = 2'd0;
                end else begin
                    phase_nxt = phase + 2'd1;
                end
            end
            HAZ: begin
                if (phase == 2'd3) begin
                    state_nxt = decoded;
                    phase_nxt = 2'd0;
                end else begin
                    phase_nxt = phase + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = 2'd0;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so no input reaches them combinationally.
    always_comb begin
        L     = (state == LEFT) || (state == HAZ);
        R     = (state == RIGHT) || (state == HAZ);
        Busy  = (state != IDLE);
        Phase = phase;
        Step  = step_int;
    end

endmodule
